// File: rtl/triangle_scheduler.sv
// Triangle queue feeding a single shader: vertices latched on issue, start pulsed, done awaited.
// Push to start is 3 cycles from an idle empty queue; a push while full is dropped and flagged.
module triangle_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned W       = 16,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [9*W-1:0]               tri_in,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         shd_start,
  output logic [W-1:0]                 shd_v1x,
  output logic [W-1:0]                 shd_v1y,
  output logic [W-1:0]                 shd_v1z,
  output logic [W-1:0]                 shd_v2x,
  output logic [W-1:0]                 shd_v2y,
  output logic [W-1:0]                 shd_v2z,
  output logic [W-1:0]                 shd_v3x,
  output logic [W-1:0]                 shd_v3y,
  output logic [W-1:0]                 shd_v3z,
  input  logic                         shd_done,
  output logic                         busy,
  output logic [15:0]                  tri_done_cnt,
  input  logic                         err_clr,
  output logic                         overflow,
  output logic                         timeout
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned TW  = 9 * W;
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   vtx_q, vtx_d;
  logic            start_q, start_d;
  logic [WDW-1:0]  wdog_q, wdog_d;
  logic [15:0]     done_cnt_q, done_cnt_d;
  logic            ovf_q, ovf_d;
  logic            tmo_q, tmo_d;

  logic            full_w;
  logic            push_ok;
  logic            push_drop;
  logic            pop;
  logic            tmo_hit;
  logic            tmo_set;

  assign full_w    = (count_q == CW'(DEPTH));
  assign push_ok   = push && !full_w;
  // A push while full is dropped even if the FSM dequeues in the same cycle.
  assign push_drop = push && full_w;
  assign tmo_hit   = (TIMEOUT != 0) && (32'(wdog_q) == TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= tri_in;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    vtx_d      = vtx_q;
    start_d    = 1'b0;
    wdog_d     = wdog_q;
    done_cnt_d = done_cnt_q;
    pop        = 1'b0;
    tmo_set    = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          vtx_d    = mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + PW'(1);
          pop      = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // The start pulse is registered, so the shader sees it in the first WAIT cycle.
        start_d = 1'b1;
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + WDW'(1);
        if (shd_done) begin
          done_cnt_d = done_cnt_q + 16'd1;
          state_d    = IDLE;
        end else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    tmo_d = tmo_q;
    if (err_clr) begin
      ovf_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (push_drop) begin
      ovf_d = 1'b1;
    end
    if (tmo_set) begin
      tmo_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      vtx_q      <= '0;
      start_q    <= 1'b0;
      wdog_q     <= '0;
      done_cnt_q <= '0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      vtx_q      <= vtx_d;
      start_q    <= start_d;
      wdog_q     <= wdog_d;
      done_cnt_q <= done_cnt_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  assign full         = full_w;
  assign count        = count_q;
  assign shd_start    = start_q;
  assign busy         = (state_q != IDLE) || (count_q != '0);
  assign tri_done_cnt = done_cnt_q;
  assign overflow     = ovf_q;
  assign timeout      = tmo_q;

  assign shd_v1x = vtx_q[8*W +: W];
  assign shd_v1y = vtx_q[7*W +: W];
  assign shd_v1z = vtx_q[6*W +: W];
  assign shd_v2x = vtx_q[5*W +: W];
  assign shd_v2y = vtx_q[4*W +: W];
  assign shd_v2z = vtx_q[3*W +: W];
  assign shd_v3x = vtx_q[2*W +: W];
  assign shd_v3y = vtx_q[1*W +: W];
  assign shd_v3z = vtx_q[0*W +: W];

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed and randomized bench for triangle_scheduler; expected values come from
// the documented latencies and a push-order scoreboard of triangles.
module tb_triangle_scheduler;

  localparam int DEPTH = 4;
  localparam int W     = 16;
  localparam int TMO   = 100;

  logic           clk = 1'b0;
  logic           reset;
  logic           push;
  logic [9*W-1:0] tri_in;
  logic           full;
  logic [2:0]     count;
  logic           shd_start;
  logic [W-1:0]   shd_v1x, shd_v1y, shd_v1z, shd_v2x, shd_v2y, shd_v2z, shd_v3x, shd_v3y, shd_v3z;
  logic           shd_done;
  logic           busy;
  logic [15:0]    tri_done_cnt;
  logic           err_clr;
  logic           overflow;
  logic           timeout;

  triangle_scheduler #(.DEPTH(DEPTH), .W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .push(push), .tri_in(tri_in), .full(full), .count(count),
    .shd_start(shd_start),
    .shd_v1x(shd_v1x), .shd_v1y(shd_v1y), .shd_v1z(shd_v1z),
    .shd_v2x(shd_v2x), .shd_v2y(shd_v2y), .shd_v2z(shd_v2z),
    .shd_v3x(shd_v3x), .shd_v3y(shd_v3y), .shd_v3z(shd_v3z),
    .shd_done(shd_done), .busy(busy), .tri_done_cnt(tri_done_cnt),
    .err_clr(err_clr), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_done = 0;

  logic [143:0] t1, blk, nx, tm, r2, tmp;
  logic [143:0] bq [4];
  logic [143:0] oq [6];
  logic [143:0] sb [$];
  int           k, pushed, starts, done_at, c, unstable, extra_starts;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [143:0] shd_bus();
    return {shd_v1x, shd_v1y, shd_v1z, shd_v2x, shd_v2y, shd_v2z, shd_v3x, shd_v3y, shd_v3z};
  endfunction

  function automatic logic [143:0] rand_tri();
    logic [143:0] t;
    t = '0;
    for (int i = 0; i < 9; i++) t = {t[127:0], 16'($urandom)};
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!shd_start && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_start"}, shd_start, 1'b1);
  endtask

  // Wait for the triangle to issue, compare it, then answer after a short random render time.
  task automatic serve(input string tag, input logic [143:0] exp);
    wait_start(tag);
    chk({tag, "_vtx"}, shd_bus(), exp);
    repeat ($urandom_range(1, 10)) step();
    shd_done = 1'b1;
    step();
    shd_done = 1'b0;
    exp_done++;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_time_limit: observed still running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; push = 1'b0; shd_done = 1'b0; err_clr = 1'b0; tri_in = '0;
    repeat (3) step();
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", shd_start, 0);
    chk("rst_vtx", shd_bus(), 0);
    chk("rst_donecnt", tri_done_cnt, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tmo", timeout, 0);
    reset = 1'b0;
    step();

    // Single triangle with the shader answering 50 cycles after start.
    t1 = {16'h0020, 16'h0020, 16'h0000, 16'h0400, 16'h0040, 16'h0000, 16'h0200, 16'h0400, 16'h0000};
    tri_in = t1; push = 1'b1;
    step();
    push = 1'b0;
    chk("t1_count1", count, 1);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_vtx", shd_bus(), t1);
    chk("t1_count0", count, 0);
    chk("t1_nostart_yet", shd_start, 0);
    step();
    chk("t1_start", shd_start, 1);
    extra_starts = 0; unstable = 0;
    repeat (50) begin
      step();
      if (shd_start) extra_starts++;
      if (shd_bus() !== t1) unstable++;
    end
    shd_done = 1'b1;
    step();
    shd_done = 1'b0;
    exp_done++;
    chk("t1_extra_starts", extra_starts, 0);
    chk("t1_vtx_stable", unstable, 0);
    chk("t1_donecnt", tri_done_cnt, 16'(exp_done));
    chk("t1_busy_fall", busy, 0);
    chk("t1_count_end", count, 0);

    // Back-to-back: four pushes while a blocker renders fill the queue.
    blk = rand_tri();
    tri_in = blk; push = 1'b1;
    step();
    push = 1'b0;
    wait_start("blk");
    chk("blk_vtx", shd_bus(), blk);
    for (int i = 0; i < 4; i++) begin
      bq[i] = rand_tri();
      tri_in = bq[i]; push = 1'b1;
      step();
    end
    push = 1'b0;
    chk("b2b_full", full, 1);
    chk("b2b_count", count, 4);
    chk("b2b_vtx_hold", shd_bus(), blk);
    shd_done = 1'b1;
    step();
    shd_done = 1'b0;
    exp_done++;
    for (int i = 0; i < 4; i++) serve($sformatf("b2b%0d", i), bq[i]);
    chk("b2b_donecnt", tri_done_cnt, 16'(exp_done));

    // Overflow with the shader stalled.
    for (int i = 0; i < 6; i++) oq[i] = rand_tri();
    for (int i = 0; i < 5; i++) begin
      tri_in = oq[i]; push = 1'b1;
      step();
    end
    chk("ovf_pre", overflow, 0);
    chk("ovf_pre_full", full, 1);
    chk("ovf_inflight", shd_bus(), oq[0]);
    tri_in = oq[5];
    step();
    push = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 4);
    tri_in = rand_tri(); push = 1'b1; err_clr = 1'b1;
    step();
    push = 1'b0; err_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("ovf_clr", overflow, 0);

    // Push dropped while the FSM dequeues from a full queue.
    shd_done = 1'b1;
    step();
    shd_done = 1'b0;
    exp_done++;
    tri_in = rand_tri(); push = 1'b1;
    step();
    push = 1'b0;
    chk("pp_count", count, 3);
    chk("pp_ovf", overflow, 1);
    chk("pp_full", full, 0);
    chk("pp_vtx", shd_bus(), oq[1]);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int i = 1; i < 5; i++) serve($sformatf("ovfq%0d", i), oq[i]);
    chk("ovf_donecnt", tri_done_cnt, 16'(exp_done));
    chk("ovf_busy_end", busy, 0);

    // Watchdog: no done; timeout one watchdog period after the start cycle.
    tm = rand_tri();
    tri_in = tm; push = 1'b1;
    step();
    push = 1'b0;
    wait_start("tmo");
    nx = rand_tri();
    tri_in = nx; push = 1'b1;
    step();
    push = 1'b0;
    k = 1;
    while (!timeout && k < 200) begin
      step();
      k++;
    end
    chk("tmo_latency", k, TMO);
    chk("tmo_donecnt", tri_done_cnt, 16'(exp_done));
    step();
    chk("tmo_next_vtx", shd_bus(), nx);
    chk("tmo_next_nostart", shd_start, 0);
    step();
    chk("tmo_next_start", shd_start, 1);
    chk("tmo_sticky", timeout, 1);

    // Asynchronous reset between clock edges while rendering.
    r2 = rand_tri();
    tri_in = r2; push = 1'b1;
    step();
    push = 1'b0;
    chk("ar_count_pre", count, 1);
    step();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_count", count, 0);
    chk("ar_start", shd_start, 0);
    chk("ar_vtx", shd_bus(), 0);
    chk("ar_busy", busy, 0);
    chk("ar_donecnt", tri_done_cnt, 0);
    chk("ar_tmo", timeout, 0);
    chk("ar_ovf", overflow, 0);
    exp_done = 0;
    step();
    reset = 1'b0;
    step();
    shd_done = 1'b1;
    step();
    shd_done = 1'b0;
    chk("ar_late_done_cnt", tri_done_cnt, 0);
    chk("ar_late_busy", busy, 0);
    step();
    chk("ar_late_start", shd_start, 0);

    // Randomized traffic checked against an in-order scoreboard.
    pushed = 0; starts = 0; done_at = -1; c = 0;
    while (c < 4000 && (c < 800 || sb.size() != 0 || done_at >= 0)) begin
      if (shd_start) begin
        chk("rnd_start_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) chk("rnd_vtx", shd_bus(), sb.pop_front());
        starts++;
        done_at = c + $urandom_range(1, 20);
      end
      shd_done = (c == done_at);
      if (c == done_at) begin
        done_at = -1;
        exp_done++;
      end
      push = 1'b0;
      if (c < 800 && (pushed - starts) < DEPTH && $urandom_range(0, 2) != 0) begin
        tmp = rand_tri();
        tri_in = tmp; push = 1'b1;
        sb.push_back(tmp);
        pushed++;
      end
      step();
      c++;
    end
    shd_done = 1'b0; push = 1'b0;
    chk("rnd_all_started", starts, pushed);
    chk("rnd_donecnt", tri_done_cnt, 16'(exp_done));
    chk("rnd_count", count, 0);
    chk("rnd_busy", busy, 0);
    chk("rnd_ovf", overflow, 0);
    chk("rnd_tmo", timeout, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/triangle_scheduler.md
Name: triangle_scheduler

Overview:
- Queues triangle vertex sets from a host-side producer and feeds them one at a time to the shader.
- Pulses the shader's start, holds vertices stable for the whole render, waits for the shader's done pulse, then issues the next triangle.
- Sits between the host/Avalon register block and the shader. Provides backpressure (full), a busy flag, a completed-triangle counter and sticky error flags (overflow, shader timeout).

Parameters:
- DEPTH, 4, number of triangle entries in the queue (power of 2, >=2).
- W, 16, vertex coordinate width (fixed-point, 5 fractional bits, same as shader).
- TIMEOUT, 2000000, max cycles to wait for shd_done after issue; 0 disables the watchdog.

Ports:
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- push  in  1  enqueue tri_in this cycle.
- tri_in  in  9*W  {v1x,v1y,v1z,v2x,v2y,v2z,v3x,v3y,v3z}, v1x in MSBs.
- full  out  1  queue holds DEPTH entries.
- count  out  $clog2(DEPTH+1)  entries in queue (excludes the triangle in flight).
- shd_start  out  1  start to shader.
- shd_v1x..shd_v3z  out  W each  vertices to shader, stable from issue until retire.
- shd_done  in  1  one-cycle done pulse from shader.
- busy  out  1  state!=IDLE or count!=0.
- tri_done_cnt  out  16  triangles completed (wraps 0xFFFF->0).
- err_clr  in  1  clears sticky errors.
- overflow  out  1  sticky: push attempted while full.
- timeout  out  1  sticky: watchdog expired.

Behaviour:
- Reset (async, immediate): queue empty, count=0, full=0, state=IDLE, shd_start=0, shd_v*=0, tri_done_cnt=0, overflow=0, timeout=0, watchdog=0. Reset mid-render abandons the in-flight triangle; the shader is reset by the same signal.
- Queue: circular buffer, wr_ptr/rd_ptr wrap at DEPTH, registered count.
  - push && !full writes at wr_ptr.
  - push && full drops the data and sets overflow. This applies even if a dequeue happens in the same cycle; there is no write-through.
  - Simultaneous accepted push and dequeue leaves count unchanged.
- FSM:
  - IDLE: if count>0, load head entry into shd_v* registers, dequeue (rd_ptr++, count--), go ISSUE. Otherwise stay.
  - ISSUE: shd_start=1 for exactly this one cycle, clear watchdog, go WAIT.
  - WAIT: shd_start=0; watchdog increments each cycle.
    - shd_done=1: tri_done_cnt++, go IDLE.
    - Otherwise, TIMEOUT!=0 and watchdog==TIMEOUT-1: set timeout, go IDLE without incrementing tri_done_cnt.
  - shd_done outside WAIT is ignored.
- Latency:
  - Push into an empty idle queue: registered count visible next cycle; shd_v* loaded the cycle after that; shd_start high one cycle later.
  - shd_done to the next shd_start (queue non-empty): 3 cycles (IDLE, load/ISSUE).
- shd_v* change only on the IDLE->ISSUE transition.
- err_clr clears overflow and timeout. If an error event occurs in the same cycle, the set wins.
- busy is combinational from state and count.
- full=(count==DEPTH).

Test Plan:
- Single triangle: push v1=(0x0020,0x0020,0), v2=(0x0400,0x0040,0), v3=(0x0200,0x0400,0); shader model raises done 50 cycles after start -> one shd_start pulse with matching shd_v*, tri_done_cnt=1, busy falls, count=0.
- Back-to-back: push 4 triangles in 4 consecutive cycles (DEPTH=4) -> full=1 after the 4th push (before first dequeue). Triangles issue in push order; exactly one shd_start per shd_done; tri_done_cnt=4.
- Overflow: with shader stalled, push 6 triangles -> 1 issued, 4 queued, 6th dropped, overflow=1, count=4. err_clr -> overflow=0.
- Simultaneous push/pop at full: count=4 and IDLE dequeues in the same cycle as a push -> push dropped, overflow=1, count=3.
- Timeout: TIMEOUT=100, shader never asserts done -> timeout=1 exactly 100 cycles after the shd_start cycle. Next triangle issues; tri_done_cnt unchanged.
- Async reset mid-WAIT, asserted between clock edges -> all outputs go to reset values immediately; a late shd_done after reset release is ignored.
